// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: computes a result at start, holds it for a
// fixed latency, then commits it to HI/LO and requests pipeline stalls meanwhile.
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        start,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] tmp_hi_q, tmp_hi_d;
    logic [31:0] tmp_lo_q, tmp_lo_d;

    logic        is_mul;
    logic        is_div;
    logic        idle;

    // Shared multiplier: sign-extend only for signed mult, so one 64x64 product serves both.
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_den;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    always_comb begin
        is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
        is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);
        idle   = (state_q == ST_IDLE);
    end

    always_comb begin
        mul_signed = (md_op == OP_MULT);
        mul_a      = {{32{mul_signed & rs_val[31]}}, rs_val};
        mul_b      = {{32{mul_signed & rt_val[31]}}, rt_val};
        product    = mul_a * mul_b;
    end

    // Signed divide on magnitudes keeps 0x80000000 / -1 well defined (quotient wraps to itself).
    always_comb begin
        div_signed = (md_op == OP_DIV);
        neg_a      = div_signed & rs_val[31];
        neg_b      = div_signed & rt_val[31];
        mag_a      = neg_a ? (~rs_val + 32'd1) : rs_val;
        mag_b      = neg_b ? (~rt_val + 32'd1) : rt_val;
        div_den    = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quo_mag    = mag_a / div_den;
        rem_mag    = mag_a % div_den;
        quotient   = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
        remainder  = neg_a ? (~rem_mag + 32'd1) : rem_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (is_mul) begin
                    tmp_hi_d = product[63:32];
                    tmp_lo_d = product[31:0];
                    cnt_d    = MULT_CNT;
                    state_d  = ST_MUL;
                end else if (is_div) begin
                    if (rt_val == 32'd0) begin
                        tmp_hi_d = hi_q;
                        tmp_lo_d = lo_q;
                    end else begin
                        tmp_hi_d = remainder;
                        tmp_lo_d = quotient;
                    end
                    cnt_d   = DIV_CNT;
                    state_d = ST_DIV;
                end else if (md_op == OP_MTHI) begin
                    hi_d = rs_val;
                end else if (md_op == OP_MTLO) begin
                    lo_d = rs_val;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q <= 4'd1) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
        end
    end

    always_comb begin
        busy     = !idle;
        start    = idle && (is_mul || is_div);
        stall_md = d_is_md && (start || busy);
        hi       = hi_q;
        lo       = lo_q;
        case (md_op)
            OP_MFHI: md_out = hi_q;
            OP_MFLO: md_out = lo_q;
            default: md_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed table, randomized ops against a
// plain-arithmetic reference, and hand-written stall / reset sequences.
module tb_e_mdu_ctrl;

    typedef longint unsigned u64_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        start;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    e_mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_is_md  (d_is_md),
        .busy     (busy),
        .start    (start),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo),
        .md_out   (md_out)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: result {hi,lo} from the architectural definition of each op.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] old_hi,
                                               input logic [31:0] old_lo);
        longint sp, sq, sr;
        u64_t   up, uq, ur;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            4'd2: begin
                up = u64_t'(a) * u64_t'(b);
                return up;
            end
            4'd3: begin
                if (b == 32'd0) return {old_hi, old_lo};
                sq = longint'($signed(a)) / longint'($signed(b));
                sr = longint'($signed(a)) % longint'($signed(b));
                return {sr[31:0], sq[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {old_hi, old_lo};
                uq = u64_t'(a) / u64_t'(b);
                ur = u64_t'(a) % u64_t'(b);
                return {ur[31:0], uq[31:0]};
            end
            default: return {old_hi, old_lo};
        endcase
    endfunction

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        md_op = 4'd5; rs_val = h; tick();
        md_op = 4'd6; rs_val = l; tick();
        md_op = 4'd0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int cyc);
        int n;
        md_op = op; rs_val = a; rt_val = b;
        #1;
        chk({tag, " start"}, {63'd0, start}, 64'd1);
        tick();
        md_op = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk({tag, " busy_cycles"}, 64'(n), 64'(cyc));
        chk({tag, " hilo"}, {hi, lo}, exp);
        $display("%s op=%0d rs=%h rt=%h -> hi=%h lo=%h busy=%0d", tag, op, a, b, hi, lo, n);
    endtask

    initial begin
        logic [63:0] exp;
        logic [31:0] a, b, ph, pl;
        logic [3:0]  op;
        int          n;

        tbl[0] = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{4'd4, 32'h00001234, 32'h00000000, 32'h11, 32'h22, 32'h00000011, 32'h00000022};
        tbl[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 32'h00000000, 32'h80000000};
        tbl[5] = '{4'd3, 32'h00000005, 32'h00000000, 32'hDEAD, 32'hBEEF, 32'h0000DEAD, 32'h0000BEEF};
        tbl[6] = '{4'd4, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'h00000001, 32'h7FFFFFFC};
        tbl[7] = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD};
        tbl[8] = '{4'd1, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 32'h40000000, 32'h00000000};
        tbl[9] = '{4'd2, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000001, 32'h00000000};

        reset = 1'b1; md_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; d_is_md = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        chk("reset stall", {63'd0, stall_md}, 64'd0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            set_hilo(tbl[i].pre_hi, tbl[i].pre_lo);
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].rs, tbl[i].rt,
                   {tbl[i].exp_hi, tbl[i].exp_lo}, (tbl[i].op <= 4'd2) ? 5 : 10);
        end

        // md_out mux and out-of-range ops
        set_hilo(32'hCAFE0001, 32'hF00D0002);
        md_op = 4'd7; #1; chk("mfhi md_out", {32'd0, md_out}, {32'd0, 32'hCAFE0001});
        md_op = 4'd8; #1; chk("mflo md_out", {32'd0, md_out}, {32'd0, 32'hF00D0002});
        md_op = 4'd0; #1; chk("none md_out", {32'd0, md_out}, 64'd0);
        md_op = 4'd12; #1; chk("op12 start", {63'd0, start}, 64'd0);
        tick();
        chk("op12 busy", {63'd0, busy}, 64'd0);
        md_op = 4'd0;

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(1, 4));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            ph = $urandom;
            pl = $urandom;
            set_hilo(ph, pl);
            exp = ref_result(op, a, b, ph, pl);
            run_op($sformatf("rnd%0d", i), op, a, b, exp, (op <= 4'd2) ? 5 : 10);
        end

        // Stall held across a divide, then mflo in the first idle cycle
        d_is_md = 1'b1;
        md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        #1;
        n = 0;
        while (stall_md === 1'b1 && n < 40) begin
            n++;
            tick();
            md_op = 4'd0;
            #1;
        end
        chk("stall cycles", 64'(n), 64'd11);
        md_op = 4'd8; #1;
        chk("stall mflo", {32'd0, md_out}, 64'd14);
        chk("stall low after", {63'd0, stall_md}, 64'd0);
        $display("stall seq: stall cycles=%0d md_out=%h", n, md_out);
        md_op = 4'd0; d_is_md = 1'b0;
        tick();

        // No stall when D holds no md instruction
        md_op = 4'd4; rs_val = 32'd1000; rt_val = 32'd10;
        #1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (stall_md !== 1'b0) n++;
            tick();
            md_op = 4'd0;
            #1;
        end
        chk("nostall count", 64'(n), 64'd0);
        chk("nostall lo", {32'd0, lo}, 64'd100);
        $display("nostall seq: stall cycles=%0d lo=%h", n, lo);

        // Reset in the middle of a divide (cnt==4)
        set_hilo(32'h12345678, 32'h9ABCDEF0);
        md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        md_op = 4'd0;
        for (int i = 0; i < 6; i++) tick();
        chk("middiv busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst hilo", {hi, lo}, 64'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("rst no commit", {hi, lo}, 64'd0);
        $display("reset seq: busy=%0d hi=%h lo=%h", busy, hi, lo);

        // mthi after reset: single cycle, no busy
        md_op = 4'd5; rs_val = 32'hABCD0123;
        #1;
        chk("mthi start", {63'd0, start}, 64'd0);
        tick();
        md_op = 4'd0;
        chk("mthi hi", {32'd0, hi}, {32'd0, 32'hABCD0123});
        chk("mthi busy", {63'd0, busy}, 64'd0);
        $display("mthi seq: hi=%h busy=%0d", hi, busy);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
